// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and converter mode encodings for the counter/converter slice.
// The functions work on 32-bit zero-extended values, so one definition serves any WIDTH from 2 to 32.
package gray_pkg;

  typedef enum logic {
    CONV_B2G = 1'b0,
    CONV_G2B = 1'b1
  } conv_mode_e;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix-XOR chain unchanged for narrower widths.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int unsigned k = 1; k < MAX_WIDTH; k++) begin
      b[MAX_WIDTH-1-k] = b[MAX_WIDTH-k] ^ g[MAX_WIDTH-1-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational binary/Gray converter; mode selects the direction.
module gray_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [MAX_WIDTH-1:0] din_ext;

  always_comb begin
    din_ext = MAX_WIDTH'(din);
    if (mode == CONV_G2B) begin
      dout = WIDTH'(gray2bin(din_ext));
    end else begin
      dout = WIDTH'(bin2gray(din_ext));
    end
  end

endmodule

// File: rtl/gray_counter_conv.sv
// Up/down binary counter with registered Gray mirror and end flags, plus an
// independent one-cycle-latency binary/Gray conversion path.
module gray_counter_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  input  logic             conv_valid,
  input  logic             conv_mode,
  input  logic [WIDTH-1:0] conv_in,
  output logic [WIDTH-1:0] conv_out,
  output logic             conv_out_valid
);

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] conv_res;

  always_comb begin
    bin_nxt  = bin_out;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_out == '1) begin
          if (SATURATE == 0) begin
            bin_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_out + 1'b1;
        end
      end else begin
        if (bin_out == '0) begin
          if (SATURATE == 0) begin
            bin_nxt  = '1;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_out - 1'b1;
        end
      end
    end
    gray_nxt = WIDTH'(bin2gray(MAX_WIDTH'(bin_nxt)));
  end

  // Flags are computed from the next count so they line up with bin_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_out  <= '0;
      gray_out <= '0;
      at_max   <= 1'b0;
      at_min   <= 1'b1;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_nxt;
      gray_out <= gray_nxt;
      at_max   <= (bin_nxt == '1);
      at_min   <= (bin_nxt == '0);
      wrap     <= wrap_nxt;
    end
  end

  gray_conv #(
    .WIDTH(WIDTH)
  ) u_conv (
    .mode (conv_mode),
    .din  (conv_in),
    .dout (conv_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_out       <= '0;
      conv_out_valid <= 1'b0;
    end else begin
      conv_out_valid <= conv_valid;
      if (conv_valid) begin
        conv_out <= conv_res;
      end
    end
  end

endmodule
